// File: rtl/hart_pkg.sv
// rtl/hart_pkg.sv - heart sprite geometry, colour, mask bitmap and lives FSM state type.
package hart_pkg;

    localparam int HART_W = 16;
    localparam int HART_H = 16;
    localparam logic [7:0] HART_COLOR = 8'hE0;

    // Row index is offsetY; bit 15 is the leftmost column (offsetX = 0).
    localparam logic [15:0] HART_MASK [16] = '{
        16'h0000, 16'h3838, 16'h7C7C, 16'hFEFE,
        16'hFFFE, 16'hFFFE, 16'h7FFC, 16'h3FF8,
        16'h1FF0, 16'h0FE0, 16'h07C0, 16'h0380,
        16'h0100, 16'h0000, 16'h0000, 16'h0000
    };

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BLINK = 2'd1,
        ST_OVER  = 2'd2
    } hart_state_e;

endpackage

// File: rtl/hart_bitmap.sv
// rtl/hart_bitmap.sv - combinational lookup of one heart mask bit from an in-sprite offset.
module hart_bitmap
    import hart_pkg::*;
(
    input  logic [3:0] offset_x_i,
    input  logic [3:0] offset_y_i,
    output logic       mask_bit_o
);

    logic [15:0] row;

    always_comb begin
        row        = HART_MASK[offset_y_i];
        mask_bit_o = row[~offset_x_i];
    end

endmodule

// File: rtl/hart_lives_display.sv
// rtl/hart_lives_display.sv - lives counter with heart row renderer; HART_BLINK_EN enables blink/invincibility.
module hart_lives_display
    import hart_pkg::*;
#(
    parameter logic [10:0] TOP_X        = 11'd20,
    parameter logic [10:0] TOP_Y        = 11'd450,
    parameter int          MAX_LIVES    = 3,
    parameter int          SPACING      = 4,
    parameter int          BLINK_FRAMES = 60,
    parameter int          BLINK_PERIOD = 8
) (
    input  logic        clk,
    input  logic        resetN,
    input  logic [10:0] pixelX,
    input  logic [10:0] pixelY,
    input  logic        startOfFrame,
    input  logic        lifeLost,
    input  logic        livesReset,
    output logic        HartDrawingRequest,
    output logic [7:0]  hartRGB,
    output logic [2:0]  livesCount,
    output logic        gameOver
);

    hart_state_e state_q, state_d;
    logic [2:0]  lives_q, lives_d;
    logic        req_q, req_d;
    logic [7:0]  rgb_q;

    logic        hit, in_y, vis, mask_bit;
    logic [2:0]  hit_idx;
    logic [3:0]  off_x, off_y;
    logic [11:0] x0;

`ifdef HART_BLINK_EN
    localparam int CW = $clog2(BLINK_FRAMES + BLINK_PERIOD + 1);
    logic [CW-1:0] cnt_q, cnt_d, half;
    logic [2:0]    idx_q, idx_d;
    logic          phase_on;

    always_comb begin
        half     = cnt_q / CW'(BLINK_PERIOD);
        phase_on = ~half[0];
    end
`endif

    // 12-bit compares keep pixels left of / above the row from wrapping into a match.
    always_comb begin
        hit     = 1'b0;
        hit_idx = 3'd0;
        off_x   = 4'd0;
        x0      = 12'd0;
        in_y    = ({1'b0, pixelY} >= {1'b0, TOP_Y}) &&
                  ({1'b0, pixelY} <  {1'b0, TOP_Y} + 12'(HART_H));
        off_y   = 4'(pixelY - TOP_Y);
        for (int i = 0; i < MAX_LIVES; i++) begin
            x0 = {1'b0, TOP_X} + 12'(i * (HART_W + SPACING));
            if (({1'b0, pixelX} >= x0) && ({1'b0, pixelX} < x0 + 12'(HART_W))) begin
                hit     = 1'b1;
                hit_idx = 3'(i);
                off_x   = 4'(pixelX - x0[10:0]);
            end
        end
    end

    hart_bitmap u_bitmap (
        .offset_x_i (off_x),
        .offset_y_i (off_y),
        .mask_bit_o (mask_bit)
    );

    always_comb begin
        vis = (hit_idx < lives_q);
`ifdef HART_BLINK_EN
        vis = vis || ((state_q == ST_BLINK) && (hit_idx == idx_q) && phase_on);
`endif
        req_d = hit && in_y && mask_bit && vis;
    end

    always_comb begin
        state_d = state_q;
        lives_d = lives_q;
`ifdef HART_BLINK_EN
        cnt_d   = cnt_q;
        idx_d   = idx_q;
`endif
        if (livesReset) begin
            state_d = ST_IDLE;
            lives_d = 3'(MAX_LIVES);
`ifdef HART_BLINK_EN
            cnt_d   = '0;
`endif
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (lifeLost && (lives_q != 3'd0)) begin
                        lives_d = lives_q - 3'd1;
`ifdef HART_BLINK_EN
                        idx_d   = lives_q - 3'd1;
                        cnt_d   = '0;
                        state_d = ST_BLINK;
`else
                        if (lives_q == 3'd1) state_d = ST_OVER;
`endif
                    end
                end
`ifdef HART_BLINK_EN
                // Invincible while blinking: lifeLost is deliberately not examined here.
                ST_BLINK: begin
                    if (startOfFrame) begin
                        if (cnt_q == CW'(BLINK_FRAMES - 1)) begin
                            cnt_d   = '0;
                            state_d = (lives_q == 3'd0) ? ST_OVER : ST_IDLE;
                        end else begin
                            cnt_d = cnt_q + 1'b1;
                        end
                    end
                end
`endif
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state_q <= ST_IDLE;
            lives_q <= 3'(MAX_LIVES);
            req_q   <= 1'b0;
            rgb_q   <= 8'h00;
`ifdef HART_BLINK_EN
            cnt_q   <= '0;
            idx_q   <= 3'd0;
`endif
        end else begin
            state_q <= state_d;
            lives_q <= lives_d;
            req_q   <= req_d;
            rgb_q   <= req_d ? HART_COLOR : 8'h00;
`ifdef HART_BLINK_EN
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
`endif
        end
    end

    assign HartDrawingRequest = req_q;
    assign hartRGB            = rgb_q;
    assign livesCount         = lives_q;
    assign gameOver           = (state_q == ST_OVER);

endmodule

// File: tb/tb_hart_lives_display.sv
// tb/tb_hart_lives_display.sv - directed self-checking bench for hart_lives_display.
module tb_hart_lives_display;

    logic        clk = 1'b0;
    logic        resetN;
    logic [10:0] pixelX, pixelY;
    logic        startOfFrame, lifeLost, livesReset;
    logic        HartDrawingRequest;
    logic [7:0]  hartRGB;
    logic [2:0]  livesCount;
    logic        gameOver;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    hart_lives_display dut (
        .clk                (clk),
        .resetN             (resetN),
        .pixelX             (pixelX),
        .pixelY             (pixelY),
        .startOfFrame       (startOfFrame),
        .lifeLost           (lifeLost),
        .livesReset         (livesReset),
        .HartDrawingRequest (HartDrawingRequest),
        .hartRGB            (hartRGB),
        .livesCount         (livesCount),
        .gameOver           (gameOver)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic pix(input int x, input int y);
        pixelX = 11'(x);
        pixelY = 11'(y);
        tick();
    endtask

    task automatic pulse_ll;
        lifeLost = 1'b1;
        tick();
        lifeLost = 1'b0;
    endtask

    task automatic pulse_sof;
        startOfFrame = 1'b1;
        tick();
        startOfFrame = 1'b0;
    endtask

    task automatic release_reset;
        @(negedge clk);
        resetN = 1'b1;
    endtask

    initial begin
        resetN       = 1'b0;
        pixelX       = 11'd28;
        pixelY       = 11'd458;
        startOfFrame = 1'b0;
        lifeLost     = 1'b0;
        livesReset   = 1'b0;
        repeat (2) tick();
        chk("rst_req",   HartDrawingRequest, 1'b0);
        chk("rst_rgb",   hartRGB,            8'h00);
        chk("rst_lives", livesCount,         3'd3);
        chk("rst_over",  gameOver,           1'b0);
        release_reset();

        pix(28, 458);  chk("h0_centre_req", HartDrawingRequest, 1'b1);
                       chk("h0_centre_rgb", hartRGB, 8'hE0);
        pix(36, 458);  chk("gap_req", HartDrawingRequest, 1'b0);
                       chk("gap_rgb", hartRGB, 8'h00);
        pix(20, 450);  chk("mask_corner0", HartDrawingRequest, 1'b0);
        pix(21, 454);  chk("mask_row4", HartDrawingRequest, 1'b1);
        pix(19, 458);  chk("left_of_top_x", HartDrawingRequest, 1'b0);
        pix(28, 449);  chk("above_top_y", HartDrawingRequest, 1'b0);
        pix(28, 466);  chk("below_heart", HartDrawingRequest, 1'b0);
        pix(88, 458);  chk("no_heart3", HartDrawingRequest, 1'b0);
        pix(68, 458);  chk("h2_centre", HartDrawingRequest, 1'b1);

`ifdef HART_BLINK_EN
        pulse_ll();
        chk("blink_lives2", livesCount, 3'd2);
        for (int f = 0; f < 60; f++) begin
            if (f == 10) lifeLost = 1'b1;
            tick();
            lifeLost = 1'b0;
            chk($sformatf("blink_vis_f%0d", f), HartDrawingRequest, ((f / 8) % 2) == 0);
            pulse_sof();
        end
        chk("blink_ignored_ll", livesCount, 3'd2);
        tick();
        chk("idle_h2_hidden", HartDrawingRequest, 1'b0);
        chk("idle_not_over", gameOver, 1'b0);

        for (int k = 0; k < 2; k++) begin
            pulse_ll();
            chk("lives_step", livesCount, 3'(1 - k));
            repeat (59) pulse_sof();
            chk("over_before_end", gameOver, 1'b0);
            pulse_sof();
            chk("over_after_end", gameOver, k == 1);
        end
        chk("lives_zero", livesCount, 3'd0);
        pulse_ll();
        chk("sat_lives", livesCount, 3'd0);
        chk("sat_over", gameOver, 1'b1);

        livesReset = 1'b1;
        tick();
        livesReset = 1'b0;
        chk("restore_lives", livesCount, 3'd3);
        pulse_ll();
        repeat (3) pulse_sof();
        lifeLost   = 1'b1;
        livesReset = 1'b1;
        tick();
        lifeLost   = 1'b0;
        livesReset = 1'b0;
        chk("prio_lives", livesCount, 3'd3);
        chk("prio_over", gameOver, 1'b0);
        pulse_ll();
        chk("prio_idle_accepts", livesCount, 3'd2);

        pix(28, 458);
        repeat (30) pulse_sof();
        #2 resetN = 1'b0;
        #1;
        chk("async_lives", livesCount, 3'd3);
        chk("async_req", HartDrawingRequest, 1'b0);
        chk("async_rgb", hartRGB, 8'h00);
        chk("async_over", gameOver, 1'b0);
        release_reset();
        pulse_ll();
        chk("async_idle_accepts", livesCount, 3'd2);
`else
        pulse_ll();
        chk("ll_lives2", livesCount, 3'd2);
        chk("ll_old_frame_req", HartDrawingRequest, 1'b1);
        tick();
        chk("ll_h2_gone", HartDrawingRequest, 1'b0);
        lifeLost = 1'b1;
        tick();
        chk("ll_lives1", livesCount, 3'd1);
        chk("ll_not_over", gameOver, 1'b0);
        tick();
        chk("ll_lives0", livesCount, 3'd0);
        chk("ll_over", gameOver, 1'b1);
        tick();
        chk("sat_lives", livesCount, 3'd0);
        chk("sat_over", gameOver, 1'b1);
        lifeLost = 1'b0;
        pix(28, 458);
        tick();
        chk("over_h0_hidden", HartDrawingRequest, 1'b0);

        lifeLost   = 1'b1;
        livesReset = 1'b1;
        tick();
        lifeLost   = 1'b0;
        livesReset = 1'b0;
        chk("prio_lives", livesCount, 3'd3);
        chk("prio_over", gameOver, 1'b0);
        tick();
        chk("prio_h0_shown", HartDrawingRequest, 1'b1);

        pulse_ll();
        #2 resetN = 1'b0;
        #1;
        chk("async_lives", livesCount, 3'd3);
        chk("async_req", HartDrawingRequest, 1'b0);
        chk("async_rgb", hartRGB, 8'h00);
        chk("async_over", gameOver, 1'b0);
        release_reset();
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
